// File: rtl/noc_ring_node.sv
// noc_ring_node
//   Ring router node between the core's adapter and the NoC ring.
//   - Buffers flits injected by the adapter in a small FIFO (drops when full).
//   - Forwards ring traffic and FIFO traffic to the downstream node through a
//     registered output stage.
//   - Ejects bytes addressed to this node (from the ring or looped back from
//     the FIFO) to the adapter, one per cycle.
// Flit format (17b): [16] valid, [15:12] reserved, [11:8] dest, [7:0] byte.
// Ports:
//   clk            clock, posedge
//   rst            asynchronous active-low reset
//   inj_flit       injected flit from adapter (no backpressure)
//   ej_flit        {1'b1, byte} for one cycle on ejection, else 0
//   ring_in        flit from upstream node
//   ring_in_ready  ring_in consumed this cycle when valid & ready
//   ring_out       registered flit to downstream node
//   ring_out_ready downstream accepts ring_out when valid & ready
//   inj_drop       one-cycle pulse when an injected flit was dropped
//   drop_cnt       saturating count of dropped injected flits
module noc_ring_node #(
  parameter logic [3:0] NODE_ID = 4'd0,
  parameter int         DEPTH   = 4,
  parameter int         ADDR_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] inj_flit,
  output logic [8:0]  ej_flit,
  input  logic [16:0] ring_in,
  output logic        ring_in_ready,
  output logic [16:0] ring_out,
  input  logic        ring_out_ready,
  output logic        inj_drop,
  output logic [7:0]  drop_cnt
);

  typedef enum logic {RR_RING = 1'b0, RR_FIFO = 1'b1} rr_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [16:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  rr_e               rr_q, rr_d;
  logic [16:0]       ring_out_q, ring_out_d;
  logic [8:0]        ej_q, ej_d;
  logic              drop_q, drop_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [16:0] head_s;
  logic        fifo_ne_s, ring_local_s, cand_r_s, cand_f_s, loop_pop_s;
  logic        adv_s, grant_r_s, grant_f_s, pop_s, accept_s;

  // Request decode, arbitration, FIFO bookkeeping and output-stage next state
  always_comb begin
    head_s       = mem_q[rd_ptr_q];
    fifo_ne_s    = (count_q != {(ADDR_W + 1){1'b0}});
    ring_local_s = ring_in[16] && (ring_in[11:8] == NODE_ID);
    cand_r_s     = ring_in[16] && (ring_in[11:8] != NODE_ID);
    cand_f_s     = fifo_ne_s && (head_s[11:8] != NODE_ID);
    // Loopback only uses the ejector when the ring is not ejecting.
    loop_pop_s   = fifo_ne_s && (head_s[11:8] == NODE_ID) && !ring_local_s;
    adv_s        = !ring_out_q[16] || ring_out_ready;

    grant_r_s = 1'b0;
    grant_f_s = 1'b0;
    rr_d      = rr_q;
    if (adv_s) begin
      if (cand_r_s && cand_f_s) begin
        // Contested: current pointer wins, pointer moves to the loser.
        if (rr_q == RR_RING) begin
          grant_r_s = 1'b1;
          rr_d      = RR_FIFO;
        end else begin
          grant_f_s = 1'b1;
          rr_d      = RR_RING;
        end
      end else begin
        grant_r_s = cand_r_s;
        grant_f_s = cand_f_s;
      end
    end else begin
      rr_d = rr_q;
    end

    ring_in_ready = ring_local_s || grant_r_s;
    pop_s         = grant_f_s || loop_pop_s;
    // A full FIFO still accepts when the head leaves in the same cycle.
    accept_s      = inj_flit[16] && ((count_q < FULL_CNT) || pop_s);
    drop_d        = inj_flit[16] && !accept_s;

    wr_ptr_d = accept_s ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s    ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (ring_local_s) begin
      ej_d = {1'b1, ring_in[7:0]};
    end else if (loop_pop_s) begin
      ej_d = {1'b1, head_s[7:0]};
    end else begin
      ej_d = 9'h000;
    end

    // Output stage only changes when it may advance; a stalled flit is held.
    if (grant_r_s) begin
      ring_out_d = ring_in;
    end else if (grant_f_s) begin
      ring_out_d = head_s;
    end else if (adv_s) begin
      ring_out_d = 17'h00000;
    end else begin
      ring_out_d = ring_out_q;
    end
  end

  // State registers, FIFO storage and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 17'h00000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= RR_RING;
      ring_out_q <= 17'h00000;
      ej_q       <= 9'h000;
      drop_q     <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      if (accept_s) mem_q[wr_ptr_q] <= inj_flit;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      ring_out_q <= ring_out_d;
      ej_q       <= ej_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ring_out = ring_out_q;
  assign ej_flit  = ej_q;
  assign inj_drop = drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_noc_ring_node.sv
// Self-checking bench for noc_ring_node (NODE_ID=2). Expected ring_out and
// ej_flit values are queued as stimulus is planned and compared in order by a
// negedge monitor whenever the DUT presents an output.
module tb_noc_ring_node;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] inj_flit;
  logic [8:0]  ej_flit;
  logic [16:0] ring_in;
  logic        ring_in_ready;
  logic [16:0] ring_out;
  logic        ring_out_ready;
  logic        inj_drop;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [16:0] ro_q [$];
  logic [8:0]  ej_q [$];

  noc_ring_node #(.NODE_ID(4'd2), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .inj_flit(inj_flit), .ej_flit(ej_flit),
    .ring_in(ring_in), .ring_in_ready(ring_in_ready), .ring_out(ring_out),
    .ring_out_ready(ring_out_ready), .inj_drop(inj_drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(input logic [3:0] rsv, input logic [3:0] dest, input logic [7:0] b);
    return {1'b1, rsv, dest, b};
  endfunction

  // Scoreboard monitor: compare every transferred output against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (ring_out[16] && ring_out_ready) begin
        if (ro_q.size() > 0) check("ring_out", 32'(ring_out), 32'(ro_q.pop_front()));
        else check("ro_unexpected", 32'(ring_out), 32'h0);
      end
      if (ej_flit[8]) begin
        if (ej_q.size() > 0) check("ej_flit", 32'(ej_flit), 32'(ej_q.pop_front()));
        else check("ej_unexpected", 32'(ej_flit), 32'h0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; inj_flit = '0; ring_in = '0; ring_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((ro_q.size() + ej_q.size()) != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    check(tag, 32'(ro_q.size() + ej_q.size()), 32'h0);
  endtask

  logic [16:0] f [8];
  logic [16:0] r [6];
  int drops;
  int ri, fi;

  initial begin
    rst = 1'b0; inj_flit = '0; ring_in = '0; ring_out_ready = 1'b1;
    #12;
    check("rst_ring_out", 32'(ring_out), 32'h0);
    check("rst_ej", 32'(ej_flit), 32'h0);
    check("rst_drop", 32'({inj_drop, drop_cnt}), 32'h0);
    #1 rst = 1'b1;

    // 1: four injected flits appear on ring_out in order, iterations 2..5
    do_reset();
    for (int j = 0; j < 4; j++) f[j] = mk(4'hA, 4'd5, 8'(8'h11 * (j + 1)));
    for (int j = 0; j < 4; j++) ro_q.push_back(f[j]);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      inj_flit = (i < 4) ? f[i] : 17'h0;
      @(negedge clk);
      if (i >= 2 && i <= 5) check("t1_timing", 32'(ring_out), 32'(f[i-2]));
      else if (i < 2) check("t1_idle", 32'(ring_out[16]), 32'h0);
    end
    drain("t1_drain");

    // 2: ring flit for this node is ejected one cycle later
    do_reset();
    ej_q.push_back(9'h1A5);
    @(posedge clk); #1 ring_in = mk(4'h0, 4'd2, 8'hA5);
    @(negedge clk);
    check("t2_ready", 32'(ring_in_ready), 32'h1);
    @(posedge clk); #1 ring_in = '0;
    @(negedge clk);
    check("t2_ej", 32'(ej_flit), 32'h1A5);
    drain("t2_drain");

    // 3: output stalled; f0 parks in ring_out, 4 buffered, last 2 dropped
    do_reset();
    ring_out_ready = 1'b0;
    drops = 0;
    for (int j = 0; j < 7; j++) f[j] = mk(4'h3, 4'd7, 8'(8'h30 + j));
    for (int j = 0; j < 5; j++) ro_q.push_back(f[j]);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      inj_flit = (i < 7) ? f[i] : 17'h0;
      @(negedge clk);
      if (inj_drop) drops++;
      if (i >= 2) check("t3_frozen", 32'(ring_out), 32'(f[0]));
    end
    check("t3_drop_pulses", 32'(drops), 32'd2);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
    @(posedge clk); #1 ring_out_ready = 1'b1;
    drain("t3_drain");

    // 4: ring stream and FIFO contend; after reset ring wins first, then alternate
    do_reset();
    for (int j = 0; j < 6; j++) r[j] = mk(4'h5, 4'd9, 8'(8'hC0 + j));
    for (int j = 0; j < 4; j++) f[j] = mk(4'h6, 4'd9, 8'(8'h40 + j));
    ro_q.push_back(r[0]); ro_q.push_back(r[1]); ro_q.push_back(f[0]);
    ro_q.push_back(r[2]); ro_q.push_back(f[1]); ro_q.push_back(r[3]);
    ro_q.push_back(f[2]); ro_q.push_back(r[4]); ro_q.push_back(f[3]);
    ro_q.push_back(r[5]);
    ri = 0; fi = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      ring_in  = (ri < 6) ? r[ri] : 17'h0;
      inj_flit = (fi < 4) ? f[fi] : 17'h0;
      if (fi < 4) fi++;
      @(negedge clk);
      if (ring_in[16] && ring_in_ready) ri++;
    end
    @(posedge clk); #1 ring_in = '0;
    check("t4_ring_sent", 32'(ri), 32'd6);
    drain("t4_drain");

    // 5: ring ejection and FIFO loopback in the same cycle
    do_reset();
    ej_q.push_back(9'h1A5); ej_q.push_back(9'h15C);
    @(posedge clk); #1 inj_flit = mk(4'h0, 4'd2, 8'h5C);
    @(posedge clk); #1 inj_flit = '0; ring_in = mk(4'h0, 4'd2, 8'hA5);
    @(posedge clk); #1 ring_in = '0;
    @(negedge clk);
    check("t5_ring_first", 32'(ej_flit), 32'h1A5);
    @(negedge clk);
    check("t5_loop_next", 32'(ej_flit), 32'h15C);
    drain("t5_drain");

    // 6: reset mid-burst discards queued flits
    do_reset();
    ring_out_ready = 1'b0;
    for (int j = 0; j < 4; j++) f[j] = mk(4'h0, 4'd4, 8'(8'h60 + j));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 inj_flit = f[i];
    end
    @(negedge clk);
    check("t6_pre", 32'(ring_out), 32'(f[0]));
    #2 rst = 1'b0; inj_flit = '0;
    #1;
    check("t6_rst_out", 32'({ring_out, ej_flit, inj_drop, drop_cnt}), 32'h0);
    @(posedge clk); #1 rst = 1'b1; ring_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t6_after", 32'(ring_out), 32'h0);
    check("t6_queues", 32'(ro_q.size() + ej_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
